// File: rtl/red_pitaya_na_pkg.sv
// Shared definitions for the network-analyzer averager: state encoding and
// packed multi-channel bus slicing helpers.
`ifndef RED_PITAYA_NA_PKG_SV
`define RED_PITAYA_NA_PKG_SV

// Select channel idx of a packed CHANNELS*w bus (channel 0 in the LSBs).
`define NA_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]

package red_pitaya_na_pkg;

  localparam int unsigned NA_STATE_W = 2;

  typedef logic [NA_STATE_W-1:0] na_state_t;

  localparam na_state_t NA_IDLE  = 2'd0;
  localparam na_state_t NA_SLEEP = 2'd1;
  localparam na_state_t NA_AVG   = 2'd2;

endpackage

`endif

// File: rtl/red_pitaya_sat_accumulator.sv
// One averaging channel: signed accumulator with saturation and a sticky
// overflow flag.
//   clk_i, rstn_i : clock, async active-low reset
//   clr_i         : zero the accumulator (wins over en_i for the stored value)
//   ovf_clr_i     : clear the sticky overflow flag
//   en_i          : add the sign-extended sample into the accumulator
//   dat_i         : signed input sample
//   sum_c_o       : saturated acc + dat_i (combinational, used for publishing)
//   ovf_o         : sticky saturation flag
module red_pitaya_sat_accumulator #(
  parameter int unsigned INBITS  = 24,
  parameter int unsigned SUMBITS = 62
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               clr_i,
  input  logic               ovf_clr_i,
  input  logic               en_i,
  input  logic [INBITS-1:0]  dat_i,
  output logic [SUMBITS-1:0] sum_c_o,
  output logic               ovf_o
);

  localparam int unsigned EXTW = SUMBITS + 1;

  logic [SUMBITS-1:0] r_acc;
  logic               r_ovf;
  logic [EXTW-1:0]    w_ext;
  logic               w_of;

  // One guard bit exposes two's-complement overflow; clamp toward its sign.
  always_comb begin
    w_ext   = {r_acc[SUMBITS-1], r_acc} + EXTW'($signed(dat_i));
    w_of    = w_ext[EXTW-1] ^ w_ext[EXTW-2];
    sum_c_o = w_ext[SUMBITS-1:0];
    if (w_of) begin
      sum_c_o = w_ext[EXTW-1] ? {1'b1, {(SUMBITS-1){1'b0}}}
                              : {1'b0, {(SUMBITS-1){1'b1}}};
    end
  end

  // Accumulator and sticky flag; an add coinciding with a clear still flags overflow.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else begin
      if (clr_i) begin
        r_acc <= '0;
      end else if (en_i) begin
        r_acc <= sum_c_o;
      end
      if (ovf_clr_i) begin
        r_ovf <= 1'b0;
      end else if (en_i && w_of) begin
        r_ovf <= 1'b1;
      end
    end
  end

  assign ovf_o = r_ovf;

endmodule

// File: rtl/red_pitaya_na_avg_block.sv
// Multi-channel averager for network-analyzer sweeps: waits a settling delay,
// then sums CHANNELS samples over a window, publishing saturated results.
//   clk_i, rstn_i  : clock, reset (async assert, synchronised release)
//   start_i        : (re)start a run, latching sleep_i / averages_i
//   abort_i        : stop the run, keep sum_o (beats start_i)
//   continuous_i   : re-arm gaplessly after each result
//   sleep_i        : settling cycles before the first sample
//   averages_i     : samples per result
//   dat_i          : packed signed samples, ch0 in LSBs
//   sum_o          : packed published results, ch0 in LSBs
//   count_o        : samples accumulated in the current window
//   busy_o         : high in SLEEP or AVERAGE
//   valid_o        : sum_o holds a result of the current run
//   done_o         : one-cycle pulse with each sum_o update
//   ovf_o          : sticky per-channel saturation flags
module red_pitaya_na_avg_block
  import red_pitaya_na_pkg::*;
#(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned INBITS   = 24,
  parameter int unsigned SUMBITS  = 62,
  parameter int unsigned CNTBITS  = 32
) (
  input  logic                         clk_i,
  input  logic                         rstn_i,
  input  logic                         start_i,
  input  logic                         abort_i,
  input  logic                         continuous_i,
  input  logic [CNTBITS-1:0]           sleep_i,
  input  logic [CNTBITS-1:0]           averages_i,
  input  logic [CHANNELS*INBITS-1:0]   dat_i,
  output logic [CHANNELS*SUMBITS-1:0]  sum_o,
  output logic [CNTBITS-1:0]           count_o,
  output logic                         busy_o,
  output logic                         valid_o,
  output logic                         done_o,
  output logic [CHANNELS-1:0]          ovf_o
);

  logic [1:0]                  r_rst_sync;
  logic                        w_rstn;

  na_state_t                   r_state;
  na_state_t                   w_state_nxt;

  logic [CNTBITS-1:0]          r_sleep_rem;
  logic [CNTBITS-1:0]          r_avg_len;
  logic [CNTBITS-1:0]          r_count;
  logic [CHANNELS*SUMBITS-1:0] r_sum;
  logic                        r_valid;
  logic                        r_done;
  logic                        r_busy;

  logic                        w_start;
  logic                        w_last;
  logic                        w_acc_en;
  logic                        w_acc_clr;
  logic [CHANNELS*SUMBITS-1:0] w_sum_nxt;
  logic [CHANNELS-1:0]         w_ovf;

  // Reset asserts immediately, releases two edges later in this clock domain.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rstn = r_rst_sync[1];

  // State register.
  always_ff @(posedge clk_i or negedge w_rstn) begin
    if (!w_rstn) begin
      r_state <= NA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; averages == 0 completes instantly without leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (abort_i) begin
      w_state_nxt = NA_IDLE;
    end else if (start_i) begin
      if (averages_i == '0) begin
        w_state_nxt = NA_IDLE;
      end else if (sleep_i != '0) begin
        w_state_nxt = NA_SLEEP;
      end else begin
        w_state_nxt = NA_AVG;
      end
    end else begin
      case (r_state)
        NA_IDLE:  w_state_nxt = NA_IDLE;
        NA_SLEEP: if (r_sleep_rem <= CNTBITS'(1)) w_state_nxt = NA_AVG;
        NA_AVG:   if (w_last && !continuous_i) w_state_nxt = NA_IDLE;
        default:  w_state_nxt = NA_IDLE;
      endcase
    end
  end

  // Control strobes for the accumulators.
  always_comb begin
    w_start   = start_i && !abort_i;
    w_last    = (r_state == NA_AVG) && (r_count == r_avg_len - CNTBITS'(1));
    w_acc_en  = (r_state == NA_AVG) && !abort_i && !start_i;
    w_acc_clr = w_start || (w_acc_en && w_last && continuous_i);
  end

  // Counters and published result registers.
  always_ff @(posedge clk_i or negedge w_rstn) begin
    if (!w_rstn) begin
      r_sleep_rem <= '0;
      r_avg_len   <= '0;
      r_count     <= '0;
      r_sum       <= '0;
      r_valid     <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_state_nxt != NA_IDLE);
      if (abort_i) begin
        r_valid <= 1'b0;
      end else if (start_i) begin
        r_sleep_rem <= sleep_i;
        r_avg_len   <= averages_i;
        r_count     <= '0;
        if (averages_i == '0) begin
          r_sum   <= '0;
          r_valid <= 1'b1;
          r_done  <= 1'b1;
        end else begin
          r_valid <= 1'b0;
        end
      end else if (r_state == NA_SLEEP) begin
        r_sleep_rem <= r_sleep_rem - CNTBITS'(1);
      end else if (r_state == NA_AVG) begin
        if (w_last) begin
          r_sum   <= w_sum_nxt;
          r_valid <= 1'b1;
          r_done  <= 1'b1;
          r_count <= continuous_i ? '0 : r_count + CNTBITS'(1);
        end else begin
          r_count <= r_count + CNTBITS'(1);
        end
      end
    end
  end

  // One saturating accumulator per channel, all stepped in lockstep.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    red_pitaya_sat_accumulator #(
      .INBITS  (INBITS),
      .SUMBITS (SUMBITS)
    ) u_acc (
      .clk_i     (clk_i),
      .rstn_i    (w_rstn),
      .clr_i     (w_acc_clr),
      .ovf_clr_i (w_start),
      .en_i      (w_acc_en),
      .dat_i     (`NA_SLICE(dat_i, c, INBITS)),
      .sum_c_o   (`NA_SLICE(w_sum_nxt, c, SUMBITS)),
      .ovf_o     (w_ovf[c])
    );
  end

  assign sum_o   = r_sum;
  assign count_o = r_count;
  assign busy_o  = r_busy;
  assign valid_o = r_valid;
  assign done_o  = r_done;
  assign ovf_o   = w_ovf;

endmodule
